mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes the 156-bit EXE->MEM bus.
- It issues load/store transactions to a variable-latency data memory over a request/ack handshake and aligns and extends load data.
- It produces the 119-bit MEM->WB bus, plus MEM_over, MEM_wdest and MEM_pc for pipeline control and display.

Parameters:
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- MEM_valid  in  1  the bus register holds a valid instruction.
- EXE_MEM_bus_r  in  156  fields, MSB first:
  - mem_control[155:150]
  - store_data[149:118]
  - exe_result[117:86]
  - lo_result[85:54]
  - hi_write[53], lo_write[52], mfhi[51], mflo[50], mtc0[49], mfc0[48]
  - cp0r_addr[47:40], syscall[39], eret[38], rf_wen[37]
  - rf_wdest[36:32]
  - pc[31:0]
- WB_allow_in  in  1  the writeback stage accepts this cycle.
- MEM_over  out  1  the instruction has finished the memory stage.
- MEM_WB_bus  out  119  fields, MSB first:
  - addr_err[118]
  - mem_result[117:86]
  - lo_result[85:54]
  - hi_write..eret[53:38], same order as input
  - rf_wen[37]
  - rf_wdest[36:32]
  - pc[31:0]
- MEM_wdest  out  5  rf_wdest & {5{MEM_valid}}.
- MEM_pc  out  32  pc.
- dm_req  out  1  memory request.
- dm_wr  out  1  1 = store.
- dm_addr  out  ADDR_W  {exe_result[31:2],2'b00}.
- dm_wstrb  out  4  byte-lane write enables.
- dm_wdata  out  32  store data replicated to lanes.
- dm_addr_ok  in  1  request accepted this cycle.
- dm_rdata  in  32  read data, valid with dm_data_ok.
- dm_data_ok  in  1  transaction complete.

Behaviour:
- Clock and reset: single clock clk; asynchronous, active-low reset resetn.
- mem_control decode:
  - [5] load, [4] store; never both set.
  - [3:2] size: 00 byte, 01 half, 10 word, 11 reserved (treat as word).
  - [1] sign-extend loads.
  - [0] reserved, ignored.
- mem_access = MEM_valid & (load|store).
- addr_err = mem_access & ((half & exe_result[0]) | (word & exe_result[1:0]!=0)).
  - A misaligned access issues no request and completes immediately with addr_err=1.
- FSM states: IDLE, REQ, WAIT, DONE; reset to IDLE.
- IDLE:
  - If mem_access & ~addr_err: dm_req=1 this cycle.
  - dm_addr_ok -> WAIT, else -> REQ.
- REQ: dm_req=1 with address, strobe and data held stable; dm_addr_ok -> WAIT.
- WAIT: dm_req=0. On dm_data_ok: latch dm_rdata into rdata_r, -> DONE.
  - dm_data_ok never arrives in the same cycle as its own dm_addr_ok; a bench must not drive that.
- DONE: hold. On MEM_over & WB_allow_in -> IDLE.
- dm_data_ok seen outside WAIT is ignored.
- MEM_over = MEM_valid & (~(load|store) | addr_err | state==DONE).
  - MEM_over is never asserted in IDLE/REQ/WAIT for a legal access.
- Latency for a legal access with a zero-wait memory (addr_ok in the request cycle, data_ok next cycle): request in cycle 0, data_ok in cycle 1, MEM_over in cycle 2.
- Non-memory instructions: MEM_over in the same cycle as MEM_valid (combinational).
- Stores wait for dm_data_ok exactly as loads do.
- Store lanes, with off = exe_result[1:0]:
  - byte: wstrb = 4'b0001<<off, wdata = {4{store_data[7:0]}}.
  - half: wstrb = 4'b0011<<off, wdata = {2{store_data[15:0]}}.
  - word: wstrb = 4'hF, wdata = store_data.
  - dm_wstrb = 0 when dm_wr = 0.
- Load alignment:
  - byte = rdata_r[8*off+:8].
  - half = rdata_r[16*off[1]+:16].
  - Sign or zero extend to 32 bits per [1].
- mem_result = load & ~addr_err ? aligned load data : exe_result.
  - Stores pass exe_result through unchanged.
- Reset values:
  - state IDLE, rdata_r 0, dm_req 0.
  - MEM_over follows MEM_valid, which upstream also resets to 0.
- Reset mid-transaction: immediate return to IDLE, dm_req drops asynchronously, and the outstanding transaction is abandoned. The memory is reset by the same resetn.
- All other MEM_WB_bus fields are pure pass-through of the bus register.

Test Plan:
- ALU op: MEM_valid=1, mem_control=0, exe_result=0x12345678 -> same cycle MEM_over=1, mem_result=0x12345678, dm_req=0.
- lb signed: exe_result=0x1003, dm_rdata=0x80FF_0000, zero-wait memory -> dm_addr=0x1000, MEM_over in cycle 2, mem_result=0xFFFFFF80. Same stimulus with lbu -> 0x00000080.
- sh: exe_result=0x2002, store_data=0xAAAA_BEEF -> dm_wr=1, dm_wstrb=4'b1100, dm_wdata=0xBEEF_BEEF; MEM_over after data_ok.
- Back-pressure: dm_addr_ok held low 3 cycles -> dm_req high and dm_addr/dm_wstrb/dm_wdata stable for 4 cycles. Then WB_allow_in=0 for 2 cycles after DONE -> MEM_over stays 1 and mem_result stable.
- lw misaligned: exe_result=0x3001 -> no dm_req, MEM_over=1 same cycle, addr_err=1.
- Reset mid-op: resetn low while in WAIT -> dm_req=0, state IDLE. After release, a new lw with dm_rdata=0xCAFEF00D yields mem_result=0xCAFEF00D.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues load/store requests to a variable-latency data
// memory, aligns/extends load data and forms the MEM->WB bus.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              MEM_valid,
    input  logic [155:0]      EXE_MEM_bus_r,
    input  logic              WB_allow_in,
    output logic              MEM_over,
    output logic [118:0]      MEM_WB_bus,
    output logic [4:0]        MEM_wdest,
    output logic [31:0]       MEM_pc,
    output logic              dm_req,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [31:0]       dm_wdata,
    input  logic              dm_addr_ok,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_data_ok
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] rdata_r;

    logic [5:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;

    assign mem_control = EXE_MEM_bus_r[155:150];
    assign store_data  = EXE_MEM_bus_r[149:118];
    assign exe_result  = EXE_MEM_bus_r[117:86];
    assign rf_wdest    = EXE_MEM_bus_r[36:32];
    assign pc          = EXE_MEM_bus_r[31:0];

    // mem_control[0] is reserved and deliberately has no effect.
    logic unused_bits;
    assign unused_bits = EXE_MEM_bus_r[150];

    logic       is_load;
    logic       is_store;
    logic       size_byte;
    logic       size_half;
    logic       size_word;
    logic       sign_ext;
    logic [1:0] off;
    logic       mem_access;
    logic       addr_err;

    assign is_load    = mem_control[5];
    assign is_store   = mem_control[4];
    assign size_byte  = (mem_control[3:2] == 2'b00);
    assign size_half  = (mem_control[3:2] == 2'b01);
    assign size_word  = mem_control[3];
    assign sign_ext   = mem_control[1];
    assign off        = exe_result[1:0];

    assign mem_access = MEM_valid & (is_load | is_store);
    assign addr_err   = mem_access & ((size_half & off[0]) | (size_word & (off != 2'b00)));

    // Sequencing of one memory transaction; rdata_r keeps load data until writeback takes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            rdata_r <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_access && !addr_err) begin
                        state <= dm_addr_ok ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (dm_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dm_data_ok) begin
                        rdata_r <= dm_rdata;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (MEM_over && WB_allow_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The IDLE request is combinational so a zero-wait memory can accept it in cycle 0.
    assign dm_req = resetn & (((state == IDLE) & mem_access & ~addr_err) | (state == REQ));
    assign dm_wr  = MEM_valid & is_store;
    assign dm_addr = ADDR_W'({exe_result[31:2], 2'b00});

    always_comb begin
        dm_wstrb = 4'h0;
        dm_wdata = store_data;
        if (size_byte) begin
            dm_wstrb = 4'b0001 << off;
            dm_wdata = {4{store_data[7:0]}};
        end else if (size_half) begin
            dm_wstrb = 4'b0011 << off;
            dm_wdata = {2{store_data[15:0]}};
        end else begin
            dm_wstrb = 4'hF;
            dm_wdata = store_data;
        end
        if (!dm_wr) begin
            dm_wstrb = 4'h0;
        end
    end

    logic [7:0]  byte_data;
    logic [15:0] half_data;
    logic [31:0] load_data;

    assign byte_data = rdata_r[{off, 3'b000} +: 8];
    assign half_data = rdata_r[{off[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata_r;
        if (size_byte) begin
            load_data = {{24{sign_ext & byte_data[7]}}, byte_data};
        end else if (size_half) begin
            load_data = {{16{sign_ext & half_data[15]}}, half_data};
        end
    end

    logic [31:0] mem_result;
    assign mem_result = (is_load & ~addr_err) ? load_data : exe_result;

    assign MEM_over   = MEM_valid & (~(is_load | is_store) | addr_err | (state == DONE));
    assign MEM_WB_bus = {addr_err, mem_result, EXE_MEM_bus_r[85:0]};
    assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
    assign MEM_pc     = pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle decode vectors from a table, then
// hand-written multi-cycle sequences for handshakes, back-pressure and reset.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         MEM_valid;
    logic [155:0] EXE_MEM_bus_r;
    logic         WB_allow_in;
    logic         MEM_over;
    logic [118:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;
    logic         dm_req;
    logic         dm_wr;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wstrb;
    logic [31:0]  dm_wdata;
    logic         dm_addr_ok;
    logic [31:0]  dm_rdata;
    logic         dm_data_ok;

    int tests_run = 0;
    int tests_failed = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .MEM_valid    (MEM_valid),
        .EXE_MEM_bus_r(EXE_MEM_bus_r),
        .WB_allow_in  (WB_allow_in),
        .MEM_over     (MEM_over),
        .MEM_WB_bus   (MEM_WB_bus),
        .MEM_wdest    (MEM_wdest),
        .MEM_pc       (MEM_pc),
        .dm_req       (dm_req),
        .dm_wr        (dm_wr),
        .dm_addr      (dm_addr),
        .dm_wstrb     (dm_wstrb),
        .dm_wdata     (dm_wdata),
        .dm_addr_ok   (dm_addr_ok),
        .dm_rdata     (dm_rdata),
        .dm_data_ok   (dm_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        valid;
        logic [5:0]  mc;
        logic [31:0] sdata;
        logic [31:0] exe;
        logic        over;
        logic        req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] result;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [155:0] make_bus(input logic [5:0] mc, input logic [31:0] sd,
                                              input logic [31:0] exe, input logic [4:0] wdest,
                                              input logic [31:0] pc);
        return {mc, sd, exe, 32'h0BADF00D ^ pc, 16'hA5C3, 1'b1, wdest, pc};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [155:0] bus, input logic addr_ok,
                                 input logic data_ok, input logic [31:0] rdata, input logic wb_allow);
        MEM_valid     = valid;
        EXE_MEM_bus_r = bus;
        dm_addr_ok    = addr_ok;
        dm_data_ok    = data_ok;
        dm_rdata      = rdata;
        WB_allow_in   = wb_allow;
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        resetn = 1'b1;
    endtask

    // Zero-wait load: request accepted in cycle 0, data in cycle 1, result in cycle 2.
    task automatic runLoad(input string name, input logic [5:0] mc, input logic [31:0] exe,
                           input logic [31:0] rdata, input logic [31:0] exp);
        logic [155:0] bus;
        bus = make_bus(mc, 32'h0, exe, 5'd9, 32'h00400100);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput({name, " c0 req"}, dm_req, 1'b1);
        checkOutput({name, " c0 addr"}, dm_addr, {exe[31:2], 2'b00});
        checkOutput({name, " c0 over"}, MEM_over, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b0, 1'b1, rdata, 1'b1);
        #1;
        checkOutput({name, " c1 req"}, dm_req, 1'b0);
        checkOutput({name, " c1 over"}, MEM_over, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b0, 1'b0, 32'h11111111, 1'b1);
        #1;
        checkOutput({name, " c2 over"}, MEM_over, 1'b1);
        checkOutput({name, " c2 result"}, MEM_WB_bus[117:86], exp);
        checkOutput({name, " c2 err"}, MEM_WB_bus[118], 1'b0);
    endtask

    initial begin
        logic [155:0] bus;
        logic [4:0]   wd;
        logic [31:0]  pcv;

        vecs[0]  = '{1'b1, 6'b000000, 32'h00000000, 32'h12345678, 1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 32'h12345678};
        vecs[1]  = '{1'b1, 6'b101000, 32'h00000000, 32'h00003001, 1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 32'h00003001};
        vecs[2]  = '{1'b1, 6'b100110, 32'h00000000, 32'h00004003, 1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 32'h00004003};
        vecs[3]  = '{1'b1, 6'b010100, 32'hAAAABEEF, 32'h00002002, 1'b0, 1'b1, 1'b1, 4'hC, 32'hBEEFBEEF, 1'b0, 32'h00002002};
        vecs[4]  = '{1'b1, 6'b010000, 32'h123456A5, 32'h00005001, 1'b0, 1'b1, 1'b1, 4'h2, 32'hA5A5A5A5, 1'b0, 32'h00005001};
        vecs[5]  = '{1'b1, 6'b011000, 32'hDEADBEEF, 32'h00006004, 1'b0, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00006004};
        vecs[6]  = '{1'b1, 6'b011100, 32'h01020304, 32'h00007008, 1'b0, 1'b1, 1'b1, 4'hF, 32'h01020304, 1'b0, 32'h00007008};
        vecs[7]  = '{1'b0, 6'b101000, 32'h00000000, 32'h00003001, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 32'h00000000};
        vecs[8]  = '{1'b1, 6'b101000, 32'h00000000, 32'h00008000, 1'b0, 1'b1, 1'b0, 4'h0, 32'h00000000, 1'b0, 32'h00000000};
        vecs[9]  = '{1'b1, 6'b010011, 32'h000000C3, 32'h0000900B, 1'b0, 1'b1, 1'b1, 4'h8, 32'hC3C3C3C3, 1'b0, 32'h0000900B};
        vecs[10] = '{1'b1, 6'b001110, 32'h00000055, 32'hFFFF0001, 1'b1, 1'b0, 1'b0, 4'h0, 32'h00000055, 1'b0, 32'hFFFF0001};

        resetn = 1'b0;
        applyStimulus(1'b1, make_bus(6'b101000, 32'h0, 32'h00001000, 5'd1, 32'h0), 1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        checkOutput("reset req", dm_req, 1'b0);
        checkOutput("reset over", MEM_over, 1'b0);
        checkOutput("reset result", MEM_WB_bus[117:86], 32'h0);

        // Single-cycle decode vectors, each starting from a fresh IDLE state.
        for (int i = 0; i < 11; i++) begin
            wd  = 5'(i + 1);
            pcv = 32'h00400000 + 32'(i * 4);
            bus = make_bus(vecs[i].mc, vecs[i].sdata, vecs[i].exe, wd, pcv);
            @(negedge clk);
            resetn = 1'b0;
            #1;
            resetn = 1'b1;
            applyStimulus(vecs[i].valid, bus, 1'b0, 1'b0, 32'h0, 1'b1);
            #1;
            checkOutput($sformatf("vec%0d over", i), MEM_over, vecs[i].over);
            checkOutput($sformatf("vec%0d req", i), dm_req, vecs[i].req);
            checkOutput($sformatf("vec%0d wr", i), dm_wr, vecs[i].wr);
            checkOutput($sformatf("vec%0d wstrb", i), dm_wstrb, vecs[i].wstrb);
            checkOutput($sformatf("vec%0d wdata", i), dm_wdata, vecs[i].wdata);
            checkOutput($sformatf("vec%0d err", i), MEM_WB_bus[118], vecs[i].err);
            checkOutput($sformatf("vec%0d result", i), MEM_WB_bus[117:86], vecs[i].result);
            checkOutput($sformatf("vec%0d addr", i), dm_addr, {vecs[i].exe[31:2], 2'b00});
            checkOutput($sformatf("vec%0d pass", i), MEM_WB_bus[85:0], bus[85:0]);
            checkOutput($sformatf("vec%0d wdest", i), MEM_wdest, vecs[i].valid ? wd : 5'd0);
            checkOutput($sformatf("vec%0d pc", i), MEM_pc, pcv);
        end

        doReset();
        runLoad("lb", 6'b100010, 32'h00001003, 32'h80FF0000, 32'hFFFFFF80);
        runLoad("lbu", 6'b100000, 32'h00001003, 32'h80FF0000, 32'h00000080);

        // sh with a zero-wait memory.
        doReset();
        bus = make_bus(6'b010100, 32'hAAAABEEF, 32'h00002002, 5'd3, 32'h00400200);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("sh req", dm_req, 1'b1);
        checkOutput("sh wr", dm_wr, 1'b1);
        checkOutput("sh wstrb", dm_wstrb, 4'hC);
        checkOutput("sh wdata", dm_wdata, 32'hBEEFBEEF);
        checkOutput("sh c0 over", MEM_over, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b0, 1'b1, 32'h0, 1'b1);
        #1;
        checkOutput("sh c1 over", MEM_over, 1'b0);
        checkOutput("sh c1 req", dm_req, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("sh c2 over", MEM_over, 1'b1);
        checkOutput("sh c2 result", MEM_WB_bus[117:86], 32'h00002002);

        // lh with addr_ok held off 3 cycles, a stray data_ok in REQ, then WB stall.
        doReset();
        bus = make_bus(6'b100110, 32'h13579BDF, 32'h00009002, 5'd4, 32'h00400300);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            applyStimulus(1'b1, bus, (c == 3), (c == 1), 32'hDEAD0000, 1'b0);
            #1;
            checkOutput($sformatf("bp c%0d req", c), dm_req, 1'b1);
            checkOutput($sformatf("bp c%0d addr", c), dm_addr, 32'h00009000);
            checkOutput($sformatf("bp c%0d wstrb", c), dm_wstrb, 4'h0);
            checkOutput($sformatf("bp c%0d wdata", c), dm_wdata, 32'h9BDF9BDF);
            checkOutput($sformatf("bp c%0d over", c), MEM_over, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("bp wait req", dm_req, 1'b0);
        checkOutput("bp wait over", MEM_over, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b0, 1'b1, 32'h80011234, 1'b0);
        #1;
        checkOutput("bp data over", MEM_over, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(1'b1, bus, 1'b0, (c == 1), 32'h00000000, (c == 2));
            #1;
            checkOutput($sformatf("bp done%0d over", c), MEM_over, 1'b1);
            checkOutput($sformatf("bp done%0d result", c), MEM_WB_bus[117:86], 32'hFFFF8001);
        end
        @(negedge clk);
        applyStimulus(1'b0, bus, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("bp idle over", MEM_over, 1'b0);

        // Reset while waiting for data, then a fresh lw must start from IDLE.
        doReset();
        bus = make_bus(6'b101000, 32'h0, 32'h0000A000, 5'd5, 32'h00400400);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("rst c0 req", dm_req, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, bus, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("rst wait req", dm_req, 1'b0);
        resetn = 1'b0;
        MEM_valid = 1'b0;
        #1;
        checkOutput("rst mid req", dm_req, 1'b0);
        checkOutput("rst mid over", MEM_over, 1'b0);
        resetn = 1'b1;
        runLoad("lw after reset", 6'b101000, 32'h0000B000, 32'hCAFEF00D, 32'hCAFEF00D);

        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
